uart_rx_8x: RTL and testbench
=============================

UART_RX_8X -- requirements
Module: uart_rx_8x

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame (legal 5..8).
REQ-002 SHALL have parameter OVERSAMPLE, default 8, number of baud_8x ticks per bit (power of two, legal 4..16).
REQ-003 SHALL have port clk  input  1  system clock; the single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port baud_8x  input  1  oversample square wave from the baud generator, synchronous to clk.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port data  output  DATA_BITS  last received word, LSB first on the line.
REQ-008 SHALL have port data_valid  output  1  one-clk pulse, data holds a good frame.
REQ-009 SHALL have port frame_err  output  1  one-clk pulse, stop bit sampled low.
REQ-010 SHALL have port parity_err  output  1  one-clk pulse, parity mismatch.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer (rx_s); all sampling uses rx_s.
REQ-013 SHALL derive tick, a one-clk pulse, on each rising edge of baud_8x (prev-value register); nothing advances between ticks.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-015 IDLE: tick with rx_s=0 -> START, tick counter cleared; that tick is tick 0.
REQ-016 START: at tick OVERSAMPLE/2 rx_s=1 -> IDLE (glitch, no flags); rx_s=0 -> DATA, counter cleared.
REQ-017 DATA: every OVERSAMPLE ticks sample rx_s into shift register LSB first; after DATA_BITS samples -> PARITY if enabled, else STOP.
REQ-018 PARITY: after OVERSAMPLE ticks sample parity bit, compare with even parity of received bits, -> STOP.
REQ-019 STOP: after OVERSAMPLE ticks sample rx_s; high -> IDLE, low -> WAIT_HIGH.
REQ-020 On stop sample, data SHALL load the shift register in the following clk regardless of errors.
REQ-021 Stop high and no parity error -> data_valid pulses in the same clk data loads (latency 1 clk after the stop-sample tick).
REQ-022 Stop low -> frame_err pulses, data_valid stays low; a parity error at the same time also pulses parity_err.
REQ-023 Parity mismatch -> parity_err pulses, data_valid stays low.
REQ-024 WAIT_HIGH: stay until a tick with rx_s=1, then -> IDLE; no start detection (break/stuck-low tolerance).
REQ-025 data_valid, frame_err, parity_err SHALL be exactly one clk wide, never repeat for one frame.
REQ-026 data SHALL hold its value until the next completed frame.
REQ-027 Tick counter SHALL be log2(OVERSAMPLE) bits wide, wrap to 0 at each bit sample point.

Reset
REQ-028 rst SHALL force state IDLE, counters 0, shift register 0, data 0, data_valid/frame_err/parity_err/busy 0.
REQ-029 rst SHALL set both synchronizer flops to 1 and the baud_8x prev register to 1, so no false start or tick on the first clk after reset.
REQ-030 rst asserted mid-frame SHALL discard the frame; no flag pulses for it.

Configuration
REQ-031 Macro UART_RX_PARITY_EN defined: PARITY state present, one even-parity bit expected between data and stop.
REQ-032 Macro UART_RX_PARITY_EN undefined: no PARITY state, frame is start + DATA_BITS + stop, parity_err tied 0.

Verification
REQ-033 Frame 0xA5, no parity, clean line -> one data_valid pulse, data=0xA5, frame_err=0, busy low after.
REQ-034 rx low for 2 ticks then high -> return to IDLE, no pulses, data unchanged.
REQ-035 Frame 0x3C with stop bit low, line held low 20 ticks -> frame_err pulse, data=0x3C, no data_valid, no new start until rx high.
REQ-036 With UART_RX_PARITY_EN, 0x07 with parity bit 0 -> parity_err pulse, no data_valid; parity bit 1 -> data_valid, data=0x07.
REQ-037 rst pulsed during bit 4 of 0xFF, then frame 0x12 -> only one data_valid, data=0x12.
REQ-038 Back-to-back frames 0x55, 0xAA, no idle gap -> two data_valid pulses in order, values 0x55 then 0xAA.

Source files
------------

// File: rtl/uart_rx_8x.sv
// Oversampling UART receiver: start-bit validation, LSB-first data, optional even parity, stop check.
// Define UART_RX_PARITY_EN to expect one even-parity bit between the data bits and the stop bit.
module uart_rx_8x #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_8x,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StWaitHigh
  } state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 dv_q, dv_d;
  logic                 fe_q, fe_d;
  logic                 rx_meta_q, rx_s_q;
  logic                 baud_prev_q;
  logic                 tick;
  logic                 perr;

`ifdef UART_RX_PARITY_EN
  logic par_err_q, par_err_d;
  logic pe_q, pe_d;
  assign perr       = par_err_q;
  assign parity_err = pe_q;
`else
  assign perr       = 1'b0;
  assign parity_err = 1'b0;
`endif

  // Prev register resets high so a baud_8x already high after reset is not seen as an edge.
  assign tick = baud_8x & ~baud_prev_q;

  assign data       = data_q;
  assign data_valid = dv_q;
  assign frame_err  = fe_q;
  assign busy       = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      dv_q        <= 1'b0;
      fe_q        <= 1'b0;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      baud_prev_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
      pe_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      dv_q        <= dv_d;
      fe_q        <= fe_d;
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      baud_prev_q <= baud_8x;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= par_err_d;
      pe_q        <= pe_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    dv_d      = 1'b0;
    fe_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
    pe_d      = 1'b0;
`endif
    if (tick) begin
      case (state_q)
        StIdle: begin
          if (!rx_s_q) begin
            state_d = StStart;
            cnt_d   = '0;
          end
        end
        StStart: begin
          // Re-check the line half a bit in to reject glitches.
          if (cnt_q == CntHalf) begin
            cnt_d = '0;
            if (rx_s_q) begin
              state_d = StIdle;
            end else begin
              state_d   = StData;
              bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
              par_err_d = 1'b0;
`endif
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StData: begin
          // Counter wraps to 0 on the sample tick because OVERSAMPLE is a power of two.
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BitLast) begin
`ifdef UART_RX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            par_err_d = rx_s_q ^ (^shift_q);
            state_d   = StStop;
          end
        end
`endif
        StStop: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            data_d = shift_q;
            dv_d   = rx_s_q & ~perr;
            fe_d   = ~rx_s_q;
`ifdef UART_RX_PARITY_EN
            pe_d   = perr;
`endif
            state_d = rx_s_q ? StIdle : StWaitHigh;
          end
        end
        StWaitHigh: begin
          // A held-low line (break) must return high before a new start is accepted.
          if (rx_s_q) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_8x.sv
// Directed and randomized frames against a word-level scoreboard of expected receiver outcomes.
module tb_uart_rx_8x;

  localparam int unsigned DB        = 8;
  localparam int unsigned OS        = 8;
  localparam int unsigned TICK_CLKS = 8;
  localparam int unsigned BIT_CLKS  = OS * TICK_CLKS;

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic          baud_8x = 1'b0;
  logic          rx      = 1'b1;
  logic [DB-1:0] data;
  logic          data_valid;
  logic          frame_err;
  logic          parity_err;
  logic          busy;

  uart_rx_8x #(
    .DATA_BITS (DB),
    .OVERSAMPLE(OS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_8x   (baud_8x),
    .rx        (rx),
    .data      (data),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    repeat (TICK_CLKS / 2) @(negedge clk);
    baud_8x = ~baud_8x;
  end

  int            n_cmp    = 0;
  int            n_err    = 0;
  int            obs_dv   = 0;
  int            obs_fe   = 0;
  int            obs_pe   = 0;
  int            obs_spur = 0;
  logic [DB-1:0] obs_dv_q[$];
  logic [DB-1:0] data_prev = '0;

  logic [DB-1:0] exp_q[$];
  int            exp_fe   = 0;
  int            exp_pe   = 0;
  logic [DB-1:0] exp_data = '0;
  int            chk_idx  = 0;

  // Output monitor: every clk a flag is high counts as one pulse; data may only move with a flag.
  initial forever begin
    @(posedge clk);
    #1;
    if (data_valid === 1'b1) begin
      obs_dv++;
      obs_dv_q.push_back(data);
    end
    if (frame_err === 1'b1) obs_fe++;
    if (parity_err === 1'b1) obs_pe++;
    if (rst !== 1'b1 && data !== data_prev && data_valid !== 1'b1 &&
        frame_err !== 1'b1 && parity_err !== 1'b1) obs_spur++;
    data_prev = data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic idle_clks(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Reference outcome of one frame from the line-level rules.
  task automatic expect_frame(input logic [DB-1:0] word, input bit par_ok, input bit stop_hi);
    if (stop_hi && par_ok) exp_q.push_back(word);
    if (!stop_hi) exp_fe++;
    if (!par_ok) exp_pe++;
    exp_data = word;
  endtask

  task automatic send_frame(input string tag, input logic [DB-1:0] word, input bit par_ok,
                            input bit stop_hi, input int extra_low_ticks);
    expect_frame(word, par_ok, stop_hi);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(word[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^word) ^ !par_ok);
`endif
    drive_bit(stop_hi);
    if (!stop_hi) begin
      rx = 1'b0;
      repeat (extra_low_ticks * TICK_CLKS) @(negedge clk);
      check({tag, " busy while held low"}, busy, 1);
      rx = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " data_valid count"}, obs_dv, exp_q.size());
    for (int i = chk_idx; i < exp_q.size(); i++) begin
      if (i < obs_dv_q.size()) check({tag, " data at data_valid"}, obs_dv_q[i], exp_q[i]);
    end
    chk_idx = exp_q.size();
    check({tag, " frame_err count"}, obs_fe, exp_fe);
    check({tag, " parity_err count"}, obs_pe, exp_pe);
    check({tag, " data hold"}, data, exp_data);
    check({tag, " busy idle"}, busy, 0);
    check({tag, " data moved without flag"}, obs_spur, 0);
  endtask

  initial begin
    logic [DB-1:0] w;
    bit            s_hi;
    bit            p_ok;
    int            gap;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset data", data, 0);
    check("reset data_valid", data_valid, 0);
    check("reset frame_err", frame_err, 0);
    check("reset parity_err", parity_err, 0);
    check("reset busy", busy, 0);

    send_frame("a5", 8'hA5, 1'b1, 1'b1, 0);
    idle_clks(2 * BIT_CLKS);
    check_all("a5");

    rx = 1'b0;
    repeat (2 * TICK_CLKS) @(negedge clk);
    check("glitch busy in start", busy, 1);
    idle_clks(2 * BIT_CLKS);
    check_all("glitch");

    send_frame("3c stop low", 8'h3C, 1'b1, 1'b0, 20);
    idle_clks(2 * BIT_CLKS);
    check_all("3c stop low");

`ifdef UART_RX_PARITY_EN
    send_frame("07 bad parity", 8'h07, 1'b0, 1'b1, 0);
    idle_clks(2 * BIT_CLKS);
    check_all("07 bad parity");
    send_frame("07 good parity", 8'h07, 1'b1, 1'b1, 0);
    idle_clks(2 * BIT_CLKS);
    check_all("07 good parity");
`endif

    // 0xFF aborted by reset during bit 4; the rest of that frame is all ones on the line.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    idle_clks(BIT_CLKS / 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_data = '0;
    check("mid-frame reset data", data, 0);
    check("mid-frame reset busy", busy, 0);
    idle_clks(5 * BIT_CLKS);
    check_all("after mid-frame reset");
    send_frame("12", 8'h12, 1'b1, 1'b1, 0);
    idle_clks(2 * BIT_CLKS);
    check_all("12 after reset");

    send_frame("55 back-to-back", 8'h55, 1'b1, 1'b1, 0);
    send_frame("aa back-to-back", 8'hAA, 1'b1, 1'b1, 0);
    idle_clks(2 * BIT_CLKS);
    check_all("back-to-back");

    for (int n = 0; n < 12; n++) begin
      w    = DB'($urandom);
      s_hi = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
      p_ok = ($urandom_range(0, 3) != 0);
`else
      p_ok = 1'b1;
`endif
      send_frame("random", w, p_ok, s_hi, int'($urandom_range(0, 20)));
      if (s_hi) gap = int'($urandom_range(0, 2 * OS));
      else gap = OS + int'($urandom_range(0, 8));
      idle_clks(gap * TICK_CLKS);
    end
    idle_clks(2 * BIT_CLKS);
    check_all("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
